// File: rtl/calc2_port_driver.sv
// calc2_port_driver: request-issue stage for one calc2 request/response port.
// Accepts host commands over valid/ready, allocates the lowest free tag,
// serialises each command onto the two-cycle calc2 request bus
// (cycle 1: cmd/op1/tag, cycle 2: op2) and retires tags from out_resp/out_tag,
// forwarding each response to the host with the original command echoed.
// Optional stale-tag reclaim is compiled in with `define CALC2_TAG_TIMEOUT_EN,
// which adds the err_timeout port and the TIMEOUT parameter.
//
// state | meaning
// IDLE  | bus idle (cmd=0, data=0); may accept a command
// OP1   | bus carries cmd, op1 and allocated tag
// OP2   | bus carries op2 (cmd=0, tag held); may accept the next command
module calc2_port_driver #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int TAG_W  = 2
`ifdef CALC2_TAG_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                    c_clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CMD_W-1:0]        req_cmd,
    input  logic [DATA_W-1:0]       req_op1,
    input  logic [DATA_W-1:0]       req_op2,
    output logic [CMD_W-1:0]        req_cmd_in,
    output logic [DATA_W-1:0]       req_data_in,
    output logic [TAG_W-1:0]        req_tag_in,
    input  logic [1:0]              out_resp,
    input  logic [DATA_W-1:0]       out_data,
    input  logic [TAG_W-1:0]        out_tag,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_resp,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [CMD_W-1:0]        rsp_cmd,
    output logic [(2**TAG_W)-1:0]   busy_tags,
`ifdef CALC2_TAG_TIMEOUT_EN
    output logic                    err_timeout,
`endif
    output logic                    err_orphan
);

    localparam int NUM_TAGS = 2**TAG_W;

    typedef enum logic [1:0] {IDLE = 2'd0, OP1 = 2'd1, OP2 = 2'd2} state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 ready_en;
    logic [TAG_W-1:0]     alloc_tag;
    logic                 any_free;
    logic                 accept;
    logic                 resp_hit;
    logic                 hit_busy;
    logic [NUM_TAGS-1:0]  set_mask;
    logic [NUM_TAGS-1:0]  clr_mask;
    logic [NUM_TAGS-1:0]  busy_d;
    logic [DATA_W-1:0]    op2_q;
    logic [CMD_W-1:0]     cmd_d;
    logic [DATA_W-1:0]    data_d;
    logic [TAG_W-1:0]     tag_d;
    logic [CMD_W-1:0]     cmd_table [NUM_TAGS];

    // Lowest-index free tag, taken from the registered (pre-edge) busy vector.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_tags[i]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    // ready_en keeps req_ready low while reset is held; ready then depends
    // only on registered state, never on req_valid.
    assign any_free  = ~&busy_tags;
    assign req_ready = ready_en && ((state_q == IDLE) || (state_q == OP2)) && any_free;
    assign accept    = req_valid && req_ready;
    assign resp_hit  = (out_resp != 2'd0);
    assign hit_busy  = busy_tags[out_tag];
    assign set_mask  = accept ? (NUM_TAGS'(1) << alloc_tag) : '0;

`ifdef CALC2_TAG_TIMEOUT_EN
    localparam int AGE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [AGE_W-1:0]     age_q [NUM_TAGS];
    logic [NUM_TAGS-1:0]  to_mask;

    // A busy tag whose age has reached TIMEOUT-1 is reclaimed this edge.
    always_comb begin
        to_mask = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            to_mask[i] = busy_tags[i] && (age_q[i] == AGE_W'(TIMEOUT - 1));
        end
    end

    // Per-tag age counters: cleared on allocate, counting while busy.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                age_q[i] <= '0;
            end
            err_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (set_mask[i] || to_mask[i]) begin
                    age_q[i] <= '0;
                end else if (busy_tags[i]) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
            if (|to_mask) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign clr_mask = ((resp_hit && hit_busy) ? (NUM_TAGS'(1) << out_tag) : '0) | to_mask;
`else
    assign clr_mask = (resp_hit && hit_busy) ? (NUM_TAGS'(1) << out_tag) : '0;
`endif

    // Set and clear act on different bits; a response on a free tag clears nothing.
    assign busy_d = (busy_tags & ~clr_mask) | set_mask;

    // FSM state register plus the out-of-reset ready enable.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
        end
    end

    // Next-state logic: one command every two cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? OP1 : IDLE;
            OP1:     state_d = OP2;
            OP2:     state_d = accept ? OP1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus values for the next cycle, registered below so the bus is glitch-free.
    always_comb begin
        cmd_d  = '0;
        data_d = '0;
        tag_d  = '0;
        case (state_d)
            OP1: begin
                cmd_d  = req_cmd;
                data_d = req_op1;
                tag_d  = alloc_tag;
            end
            OP2: begin
                data_d = op2_q;
                tag_d  = req_tag_in;
            end
            default: begin
                cmd_d  = '0;
                data_d = '0;
                tag_d  = '0;
            end
        endcase
    end

    // Registered request bus and op2 holding register.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            req_cmd_in  <= '0;
            req_data_in <= '0;
            req_tag_in  <= '0;
            op2_q       <= '0;
        end else begin
            req_cmd_in  <= cmd_d;
            req_data_in <= data_d;
            req_tag_in  <= tag_d;
            if (accept) begin
                op2_q <= req_op2;
            end
        end
    end

    // Outstanding-tag vector and per-tag command table.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy_tags <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                cmd_table[i] <= '0;
            end
        end else begin
            busy_tags <= busy_d;
            if (accept) begin
                cmd_table[alloc_tag] <= req_cmd;
            end
        end
    end

    // Response forwarding with one cycle of latency; orphans echo cmd 0.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= 1'b0;
            rsp_resp   <= '0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_cmd    <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= resp_hit;
            if (resp_hit) begin
                rsp_resp <= out_resp;
                rsp_data <= out_data;
                rsp_tag  <= out_tag;
                rsp_cmd  <= hit_busy ? cmd_table[out_tag] : '0;
                if (!hit_busy) begin
                    err_orphan <= 1'b1;
                end
            end
        end
    end

endmodule
